// File: rtl/nibble_pkg.sv
// Shared definitions for the nibble sequence detector: FSM state encoding,
// default target pattern and the saturation limit of the match counter.
package nibble_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GOT0 = 2'd1,
    GOT1 = 2'd2
  } state_t;

  localparam logic [3:0] DEF_P0  = 4'hC;
  localparam logic [3:0] DEF_P1  = 4'h6;
  localparam logic [3:0] DEF_P2  = 4'hF;
  localparam logic [3:0] CNT_MAX = 4'hF;

endpackage

// File: rtl/sat_cnt4.sv
// 4-bit saturating counter with a synchronous clear that beats increment,
// plus a registered flag that is high whenever the count sits at its maximum.
module sat_cnt4
  import nibble_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] count,
  output logic       sat
);

  logic [3:0] count_d, count_q;
  logic       sat_d, sat_q;

  // Next count: clear wins, otherwise step by one until the ceiling is reached.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 4'd1;
    end
    sat_d = (count_d == CNT_MAX);
  end

  // Count and saturation flag registers, both forced to zero by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 4'd0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/nibble_seq_det.sv
// Detects the nibble sequence P0,P1,P2 on valid samples. Restart is only
// possible through P0, so a failed attempt that lands on P0 keeps progress.
// Every completed sequence pulses match for one cycle and bumps the counter.
module nibble_seq_det
  import nibble_pkg::*;
#(
  parameter logic [3:0] P0 = DEF_P0,
  parameter logic [3:0] P1 = DEF_P1,
  parameter logic [3:0] P2 = DEF_P2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [3:0] d,
  input  logic       clear,
  output logic       match,
  output logic [3:0] count,
  output logic       sat,
  output logic [1:0] state
);

  state_t state_d, state_q;
  logic   match_d, match_q;

  // Next-state and match decode; invalid cycles hold state and never match.
  always_comb begin
    state_d = state_q;
    match_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = (d == P0) ? GOT0 : IDLE;
        end
      end
      GOT0: begin
        if (valid) begin
          if (d == P1) begin
            state_d = GOT1;
          end else if (d == P0) begin
            state_d = GOT0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GOT1: begin
        if (valid) begin
          match_d = (d == P2);
          state_d = (d == P0) ? GOT0 : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state and registered match pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  // The counter increments on the same edge that registers the match pulse.
  sat_cnt4 u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match_d),
    .clr   (clear),
    .count (count),
    .sat   (sat)
  );

  assign match = match_q;
  assign state = state_q;

endmodule

// File: tb/tb_nibble_seq_det.sv
// Bench for nibble_seq_det: hand-written vector table, directed multi-cycle
// corner cases, and random stimulus compared against a history-based model.
module tb_nibble_seq_det;

  localparam logic [3:0] TP0 = 4'hC;
  localparam logic [3:0] TP1 = 4'h6;
  localparam logic [3:0] TP2 = 4'hF;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [3:0] d;
  logic       clear;
  logic       match;
  logic [3:0] count;
  logic       sat;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: the detector fires when the last three valid nibbles
  // since reset are P0,P1,P2; progress is read from the tail of that history.
  logic [3:0] hist[$];
  int         m_count;
  int         m_match;
  int         m_state;

  typedef struct packed {
    logic       v;
    logic [3:0] dd;
    logic       clr;
    logic [1:0] st;
    logic       m;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[0:31];
  int   nvec = 0;

  nibble_seq_det #(.P0(TP0), .P1(TP1), .P2(TP2)) dut (
    .clk   (clk),
    .reset (reset),
    .valid (valid),
    .d     (d),
    .clear (clear),
    .match (match),
    .count (count),
    .sat   (sat),
    .state (state)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check1(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    hist.delete();
    m_count = 0;
    m_match = 0;
    m_state = 0;
  endtask

  task automatic modelStep(input logic v, input logic [3:0] dd, input logic clr);
    int n;
    m_match = 0;
    if (v) begin
      hist.push_back(dd);
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() == 3 && hist[0] == TP0 && hist[1] == TP1 && hist[2] == TP2)
        m_match = 1;
    end
    if (clr) m_count = 0;
    else if (m_match == 1 && m_count < 15) m_count = m_count + 1;
    n = hist.size();
    if (n >= 2 && hist[n-2] == TP0 && hist[n-1] == TP1) m_state = 2;
    else if (n >= 1 && hist[n-1] == TP0) m_state = 1;
    else m_state = 0;
  endtask

  // Drive one cycle's inputs at the falling edge, then step the model after the rising edge.
  task automatic applyStimulus(input logic v, input logic [3:0] dd, input logic clr);
    @(negedge clk);
    valid = v;
    d     = dd;
    clear = clr;
    @(posedge clk);
    #1;
    modelStep(v, dd, clr);
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, " state"}, int'(state), m_state);
    check1({tag, " match"}, int'(match), m_match);
    check1({tag, " count"}, int'(count), m_count);
    check1({tag, " sat"},   int'(sat),   (m_count == 15) ? 1 : 0);
  endtask

  task automatic checkHand(input string tag, input int st, input int m, input int cnt);
    check1({tag, " state"}, int'(state), st);
    check1({tag, " match"}, int'(match), m);
    check1({tag, " count"}, int'(count), cnt);
    check1({tag, " sat"},   int'(sat),   (cnt == 15) ? 1 : 0);
  endtask

  // Pulse reset between edges with valid/clear active to show it overrides them.
  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    valid = 1'b1;
    d     = TP0;
    clear = 1'b1;
    #2;
    checkHand("async reset", 0, 0, 0);
    @(posedge clk);
    #1;
    checkHand("held reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    modelReset();
  endtask

  task automatic addVec(input logic v, input logic [3:0] dd, input logic clr,
                        input logic [1:0] st, input logic m, input logic [3:0] cnt);
    vecs[nvec] = '{v: v, dd: dd, clr: clr, st: st, m: m, cnt: cnt};
    nvec++;
  endtask

  initial begin
    reset = 1'b1;
    valid = 1'b0;
    d     = 4'h0;
    clear = 1'b0;
    modelReset();
    #2;
    checkHand("power-on reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Basic, overlap, gap, fallback and clear vectors.
    addVec(1, 4'hC, 0, 1, 0, 0);
    addVec(1, 4'h6, 0, 2, 0, 0);
    addVec(1, 4'hF, 0, 0, 1, 1);
    addVec(1, 4'hC, 0, 1, 0, 1);
    addVec(1, 4'hC, 0, 1, 0, 1);
    addVec(1, 4'h6, 0, 2, 0, 1);
    addVec(1, 4'hF, 0, 0, 1, 2);
    addVec(1, 4'hC, 0, 1, 0, 2);
    addVec(1, 4'h6, 0, 2, 0, 2);
    addVec(1, 4'hC, 0, 1, 0, 2);
    addVec(1, 4'h6, 0, 2, 0, 2);
    addVec(1, 4'hF, 0, 0, 1, 3);
    addVec(1, 4'hC, 0, 1, 0, 3);
    addVec(0, 4'h5, 0, 1, 0, 3);
    addVec(0, 4'h6, 0, 1, 0, 3);
    addVec(0, 4'h0, 0, 1, 0, 3);
    addVec(1, 4'h6, 0, 2, 0, 3);
    addVec(0, 4'hF, 0, 2, 0, 3);
    addVec(1, 4'hF, 0, 0, 1, 4);
    addVec(1, 4'hF, 0, 0, 0, 4);
    addVec(1, 4'h6, 0, 0, 0, 4);
    addVec(0, 4'h0, 1, 0, 0, 0);
    addVec(1, 4'hC, 0, 1, 0, 0);
    addVec(1, 4'h5, 0, 0, 0, 0);
    addVec(1, 4'hC, 0, 1, 0, 0);
    addVec(1, 4'h6, 1, 2, 0, 0);
    addVec(1, 4'hC, 0, 1, 0, 0);

    for (int i = 0; i < nvec; i++) begin
      applyStimulus(vecs[i].v, vecs[i].dd, vecs[i].clr);
      checkHand($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].m), int'(vecs[i].cnt));
      checkOutput($sformatf("vec%0d model", i));
    end

    // Reset while in GOT1 discards progress; F alone afterwards must not match.
    doReset();
    applyStimulus(1, TP0, 0);
    applyStimulus(1, TP1, 0);
    checkHand("pre-reset GOT1", 2, 0, 0);
    doReset();
    applyStimulus(1, TP2, 0);
    checkHand("post-reset lone F", 0, 0, 0);
    applyStimulus(1, TP0, 0);
    applyStimulus(1, TP1, 0);
    applyStimulus(1, TP2, 0);
    checkHand("post-reset match", 0, 1, 1);

    // Saturation: 16 sequences, counter pins at 15 while match keeps pulsing.
    doReset();
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1, TP0, 0);
      applyStimulus(1, TP1, 0);
      applyStimulus(1, TP2, 0);
      checkHand($sformatf("sat seq%0d", k), 0, 1, (k > 15) ? 15 : k);
    end
    applyStimulus(0, 4'h0, 0);
    checkHand("sat idle", 0, 0, 15);

    // Clear colliding with a match at count 7: clear wins, match still pulses.
    doReset();
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, TP0, 0);
      applyStimulus(1, TP1, 0);
      applyStimulus(1, TP2, 0);
    end
    checkHand("pre-collision", 0, 1, 7);
    applyStimulus(1, TP0, 0);
    applyStimulus(1, TP1, 0);
    applyStimulus(1, TP2, 1);
    checkHand("clear collision", 0, 1, 0);
    applyStimulus(0, 4'h0, 0);
    checkHand("after collision", 0, 0, 0);

    // Random traffic biased toward pattern nibbles, with sparse clears and resets.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rd;
      logic       rv;
      logic       rc;
      case ($urandom_range(0, 3))
        0:       rd = TP0;
        1:       rd = TP1;
        2:       rd = TP2;
        default: rd = 4'($urandom_range(0, 15));
      endcase
      rv = ($urandom_range(0, 3) != 0);
      rc = ($urandom_range(0, 59) == 0);
      applyStimulus(rv, rd, rc);
      checkOutput($sformatf("rand%0d", i));
      if (i % 750 == 749) doReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
